// File: rtl/scan_display_driver.sv
// Multiplexed display scanner: gives each enabled digit a slot of 2^DUTY_W
// cycles in ascending order, gates the strobe by a brightness duty code and
// an optional blink phase, and drives only registered outputs.
//
// Handshake note: there is no valid/ready traffic here. Every input is a
// level that is sampled on each rising CP edge, and every output is a
// register that describes the slot in progress after that edge.
module scan_display_driver #(
  parameter int N_DIGITS   = 8,
  parameter int SEG_W      = 8,
  parameter int DUTY_W     = 3,
  parameter int BLINK_HALF = 500
) (
  input  logic                          CP,
  input  logic                          CR,
  input  logic [N_DIGITS*SEG_W-1:0]     display_data,
  input  logic [N_DIGITS-1:0]           digit_en,
  input  logic [N_DIGITS-1:0]           blink_mask,
  input  logic                          adjust,
  input  logic [DUTY_W-1:0]             brightness,
  output logic [N_DIGITS-1:0]           select_light,
  output logic [SEG_W-1:0]              display_char,
  output logic [$clog2(N_DIGITS)-1:0]   cur_digit,
  output logic                          frame_start
);

  localparam int CW = $clog2(N_DIGITS);
  localparam int BW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
  localparam logic [DUTY_W-1:0] SC_LAST = '1;
  localparam logic [BW-1:0]     BC_LAST = BW'(BLINK_HALF - 1);

  // ST_IDLE doubles as the "not started" flag: no digit owns a slot yet.
  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  state_t            state, state_n;
  logic [DUTY_W-1:0] sc, sc_n;
  logic [CW-1:0]     cur_n;
  logic [BW-1:0]     bc, bc_n;
  logic              bp, bp_n;
  logic              slot_start;

  // Index-ordered views of the MSB-first input buses.
  logic [N_DIGITS-1:0] en_idx;
  logic [N_DIGITS-1:0] mask_idx;
  logic [SEG_W-1:0]    seg_idx [N_DIGITS];

  logic [CW-1:0] low_idx;
  logic [CW-1:0] above_idx;
  logic          have_above;
  logic [CW-1:0] next_idx;
  logic          en_any;

  logic                lit;
  logic [N_DIGITS-1:0] sel_n;
  logic [SEG_W-1:0]    char_n;
  logic                fs_n;

  // Reorder inputs by digit index and find the lowest / next enabled digit.
  always_comb begin
    en_idx     = '0;
    mask_idx   = '0;
    low_idx    = '0;
    above_idx  = '0;
    have_above = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      en_idx[i]   = digit_en[N_DIGITS-1-i];
      mask_idx[i] = blink_mask[N_DIGITS-1-i];
      seg_idx[i]  = display_data[(N_DIGITS-i)*SEG_W-1 -: SEG_W];
    end
    // Descending scan so the last hit is the smallest qualifying index.
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (en_idx[i]) begin
        low_idx = CW'(i);
        if (CW'(i) > cur_digit) begin
          above_idx  = CW'(i);
          have_above = 1'b1;
        end
      end
    end
    en_any = |digit_en;
    // Wrapping to the lowest also covers a lone digit re-selecting itself.
    next_idx = have_above ? above_idx : low_idx;
  end

  // Next-state for the scan FSM, slot counter, blink timer and outputs.
  always_comb begin
    state_n    = state;
    sc_n       = sc;
    cur_n      = cur_digit;
    slot_start = 1'b0;
    bc_n       = '0;
    bp_n       = 1'b0;
    sel_n      = '1;
    char_n     = '1;
    fs_n       = 1'b0;
    lit        = 1'b0;

    if (!en_any) begin
      state_n = ST_IDLE;
    end else if (state == ST_IDLE || sc == SC_LAST) begin
      state_n    = ST_SCAN;
      sc_n       = '0;
      cur_n      = (state == ST_IDLE) ? low_idx : next_idx;
      slot_start = 1'b1;
    end else begin
      sc_n = sc + 1'b1;
    end

    if (adjust) begin
      if (bc == BC_LAST) begin
        bc_n = '0;
        bp_n = ~bp;
      end else begin
        bc_n = bc + 1'b1;
        bp_n = bp;
      end
    end

    // Lit decision uses the post-edge slot position and blink phase so the
    // registered outputs always describe the slot they appear in.
    lit = en_any && en_idx[cur_n] && (sc_n <= brightness) &&
          !(bp_n && mask_idx[cur_n]);

    for (int i = 0; i < N_DIGITS; i++) begin
      if (lit && cur_n == CW'(i)) sel_n[N_DIGITS-1-i] = 1'b0;
    end
    if (lit) char_n = seg_idx[cur_n];

    fs_n = slot_start && (cur_n == low_idx);
  end

  // Single register stage for state, counters and all outputs.
  always_ff @(posedge CP) begin
    if (CR) begin
      state        <= ST_IDLE;
      sc           <= '0;
      cur_digit    <= '0;
      bc           <= '0;
      bp           <= 1'b0;
      select_light <= '1;
      display_char <= '1;
      frame_start  <= 1'b0;
    end else begin
      state        <= state_n;
      sc           <= sc_n;
      cur_digit    <= cur_n;
      bc           <= bc_n;
      bp           <= bp_n;
      select_light <= sel_n;
      display_char <= char_n;
      frame_start  <= fs_n;
    end
  end

endmodule

// File: tb/tb_scan_display_driver.sv
// Directed bench for scan_display_driver at default parameters.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_scan_display_driver;

  logic        CP = 1'b0;
  logic        CR = 1'b1;
  logic [63:0] display_data;
  logic [7:0]  digit_en   = 8'hFF;
  logic [7:0]  blink_mask = 8'h00;
  logic        adjust     = 1'b0;
  logic [2:0]  brightness = 3'd7;
  logic [7:0]  select_light;
  logic [7:0]  display_char;
  logic [2:0]  cur_digit;
  logic        frame_start;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [7:0] pat [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  wire [19:0] obs = {select_light, display_char, cur_digit, frame_start};

  always #5 CP = ~CP;

  scan_display_driver dut (
    .CP           (CP),
    .CR           (CR),
    .display_data (display_data),
    .digit_en     (digit_en),
    .blink_mask   (blink_mask),
    .adjust       (adjust),
    .brightness   (brightness),
    .select_light (select_light),
    .display_char (display_char),
    .cur_digit    (cur_digit),
    .frame_start  (frame_start)
  );

  // Expected {select_light, display_char, cur_digit, frame_start}.
  function automatic logic [19:0] exp_vec(input int d, input bit lit, input bit fs);
    logic [7:0] sel;
    logic [2:0] dd;
    dd  = d[2:0];
    sel = 8'h80 >> d;
    if (lit) return {~sel, pat[d], dd, fs};
    return {8'hFF, 8'hFF, dd, fs};
  endfunction

  task automatic load_patterns();
    for (int i = 0; i < 8; i++) display_data[(8-i)*8-1 -: 8] = pat[i];
  endtask

  // Hold reset two edges with the given setup, then release.
  task automatic start_run(input logic [7:0] en, input logic [2:0] br,
                           input logic [7:0] bm, input logic adj);
    @(negedge CP);
    CR = 1'b1; digit_en = en; brightness = br; blink_mask = bm; adjust = adj;
    @(negedge CP);
    @(negedge CP);
    CR = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CP);
    @(negedge CP);
    chk_cnt++;
    if (select_light !== 8'hFF) $display("FAIL reset_sel got %h exp ff", select_light);
    else pass_cnt++;
    chk_cnt++;
    if (display_char !== 8'hFF) $display("FAIL reset_char got %h exp ff", display_char);
    else pass_cnt++;
    chk_cnt++;
    if (cur_digit !== 3'd0) $display("FAIL reset_cur got %0d exp 0", cur_digit);
    else pass_cnt++;
    chk_cnt++;
    if (frame_start !== 1'b0) $display("FAIL reset_fs got %b exp 0", frame_start);
    else pass_cnt++;
  endtask

  task automatic test_full_scan();
    logic [19:0] e;
    int d;
    start_run(8'hFF, 3'd7, 8'h00, 1'b0);
    for (int c = 0; c < 128; c++) begin
      @(negedge CP);
      d = (c / 8) % 8;
      e = exp_vec(d, 1'b1, (c % 64) == 0);
      chk_cnt++;
      if (obs !== e) $display("FAIL full_scan c=%0d got %h exp %h", c, obs, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_sparse();
    logic [19:0] e;
    int d;
    start_run(8'hA0, 3'd7, 8'h00, 1'b0);
    for (int c = 0; c < 32; c++) begin
      @(negedge CP);
      d = ((c / 8) % 2 == 0) ? 0 : 2;
      e = exp_vec(d, 1'b1, (c % 16) == 0);
      chk_cnt++;
      if (obs !== e) $display("FAIL sparse c=%0d got %h exp %h", c, obs, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_brightness();
    logic [19:0] e;
    int d;
    start_run(8'hFF, 3'd2, 8'h00, 1'b0);
    for (int c = 0; c < 64; c++) begin
      @(negedge CP);
      d = c / 8;
      e = exp_vec(d, (c % 8) <= 2, (c % 64) == 0);
      chk_cnt++;
      if (obs !== e) $display("FAIL brightness c=%0d got %h exp %h", c, obs, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_blink();
    logic [19:0] e;
    int d;
    bit bp;
    start_run(8'hFF, 3'd7, 8'h20, 1'b1);
    for (int c = 0; c < 1576; c++) begin
      if (c == 1556) adjust = 1'b0;
      @(negedge CP);
      d  = (c / 8) % 8;
      bp = (c >= 1556) ? 1'b0 : (((c + 1) / 500) % 2 == 1);
      e  = exp_vec(d, !(d == 2 && bp), (c % 64) == 0);
      chk_cnt++;
      if (obs !== e) $display("FAIL blink c=%0d got %h exp %h", c, obs, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_slot();
    logic [19:0] e;
    start_run(8'hFF, 3'd7, 8'h00, 1'b0);
    for (int c = 0; c < 30; c++) begin
      @(negedge CP);
      e = exp_vec(c / 8, 1'b1, c == 0);
      chk_cnt++;
      if (obs !== e) $display("FAIL pre_reset c=%0d got %h exp %h", c, obs, e);
      else pass_cnt++;
    end
    CR = 1'b1;
    @(negedge CP);
    chk_cnt++;
    if (obs !== 20'hFFFF0) $display("FAIL mid_reset got %h exp ffff0", obs);
    else pass_cnt++;
    CR = 1'b0;
    @(negedge CP);
    e = exp_vec(0, 1'b1, 1'b1);
    chk_cnt++;
    if (obs !== e) $display("FAIL post_reset got %h exp %h", obs, e);
    else pass_cnt++;
  endtask

  task automatic test_disable();
    logic [19:0] e;
    start_run(8'hFF, 3'd7, 8'h00, 1'b0);
    for (int c = 0; c < 21; c++) @(negedge CP);
    digit_en = 8'h00;
    for (int c = 0; c < 3; c++) begin
      @(negedge CP);
      chk_cnt++;
      if (obs !== {8'hFF, 8'hFF, 3'd2, 1'b0}) $display("FAIL disable c=%0d got %h exp ffff4", c, obs);
      else pass_cnt++;
    end
    digit_en = 8'h10;
    for (int c = 0; c < 24; c++) begin
      @(negedge CP);
      e = exp_vec(3, 1'b1, (c % 8) == 0);
      chk_cnt++;
      if (obs !== e) $display("FAIL single c=%0d got %h exp %h", c, obs, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_enable_drop();
    logic [19:0] e;
    int d;
    start_run(8'hFF, 3'd7, 8'h00, 1'b0);
    for (int c = 0; c < 32; c++) begin
      if (c == 10) digit_en = 8'hBF;
      @(negedge CP);
      d = (c < 16) ? c / 8 : ((c < 24) ? 2 : 3);
      e = exp_vec(d, !(d == 1 && c >= 10), c == 0);
      chk_cnt++;
      if (obs !== e) $display("FAIL enable_drop c=%0d got %h exp %h", c, obs, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_live_data();
    logic [19:0] e;
    start_run(8'h80, 3'd7, 8'h00, 1'b0);
    for (int c = 0; c < 16; c++) begin
      if (c == 4) display_data[63:56] = 8'h5A;
      @(negedge CP);
      e = {8'h7F, (c >= 4) ? 8'h5A : pat[0], 3'd0, (c % 8) == 0};
      chk_cnt++;
      if (obs !== e) $display("FAIL live_data c=%0d got %h exp %h", c, obs, e);
      else pass_cnt++;
    end
    load_patterns();
  endtask

  initial begin
    load_patterns();
    test_reset();
    test_full_scan();
    test_sparse();
    test_brightness();
    test_blink();
    test_reset_mid_slot();
    test_disable();
    test_enable_drop();
    test_live_data();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
